sha3_pad_axis: RTL and testbench
================================

SHA3_PAD_AXIS -- requirements
Module: sha3_pad_axis

Interface
REQ-001 Parameter WIDTH, default 16, stream word width in bits; only 16 is supported.
REQ-002 Parameter PAD_BYTE, default 8'h06, domain-separation/first pad byte (8'h1F reserved for SHAKE use).
REQ-003 ACLK  in  1  rising-edge clock for all logic.
REQ-004 ARESETn  in  1  synchronous, active-low reset, sampled on the ACLK rising edge.
REQ-005 S_TDATA  in  16  message bytes; earlier byte in [7:0], later byte in [15:8].
REQ-006 S_TKEEP  in  2  byte valid; 2'b11 full word, 2'b01 low byte only, 2'b00 no bytes.
REQ-007 S_TLAST  in  1  final word of the message.
REQ-008 S_TUSER  in  2  hash select (0 SHA3-224, 1 -256, 2 -384, 3 -512).
REQ-009 S_TVALID  in  1 / S_TREADY  out  1  upstream AXI-Stream handshake.
REQ-010 M_TDATA  out  16  padded rate-block word to the SHA core.
REQ-011 M_TVALID  out  1 / M_TREADY  in  1  downstream AXI-Stream handshake.
REQ-012 M_TLAST  out  1  last word of the last block of the message.
REQ-013 M_TUSER  out  2  hash select latched for the current message.
REQ-014 M_BLKEND  out  1  last word of each rate block.

Function
REQ-015 Rate R in 16-bit words per latched mode SHALL be: mode 0 -> 72, 1 -> 68, 2 -> 52, 3 -> 36.
REQ-016 States SHALL be IDLE, DATA, PAD; IDLE->DATA on first accepted word; DATA->PAD on accepted S_TLAST word unless padding completes in that word; PAD->IDLE on handshake of the M_TLAST word; DATA->IDLE on handshake of a self-completing S_TLAST word.
REQ-017 S_TUSER SHALL be latched only on the first accepted word in IDLE; later S_TUSER values within the message are ignored.
REQ-018 Output stage SHALL be a single register: 1-cycle latency S->M, one word per cycle sustained when M_TREADY=1.
REQ-019 S_TREADY SHALL be 1 only in IDLE/DATA and when (!M_TVALID || M_TREADY); 0 throughout PAD.
REQ-020 While M_TVALID=1 and M_TREADY=0, M_TDATA/M_TLAST/M_BLKEND/M_TUSER SHALL hold stable.
REQ-021 Word counter wc (0..R-1) SHALL advance on every M handshake and wrap to 0 after R-1; M_BLKEND=1 exactly when wc=R-1.
REQ-022 Full data word (keep 11) SHALL pass unchanged.
REQ-023 keep 01 with TLAST SHALL emit {PAD_BYTE | (wc==R-1 ? 8'h80 : 0), data[7:0]}; message ends in that word if wc==R-1.
REQ-024 keep 11 with TLAST: PAD emits first pad word {8'h00, PAD_BYTE}, 8'h80 OR'd into the high byte if it lands on wc=R-1.
REQ-025 Remaining PAD words SHALL be 16'h0000, final word (wc=R-1) 16'h8000 with M_TLAST=1.
REQ-026 keep 11 TLAST at wc=R-1 SHALL emit the data word with M_BLKEND=1, M_TLAST=0, then one full extra pad block.
REQ-027 keep 00 with TLAST (incl. empty message in IDLE) SHALL be accepted, emit nothing for that word, and start PAD at current wc.
REQ-028 keep 00 without TLAST SHALL be accepted and dropped; keep 10 SHALL be treated as 00.
REQ-029 M_TUSER SHALL equal the latched mode for every word of the message.

Reset
REQ-030 ARESETn=0 SHALL, on the next edge, force IDLE, wc=0, mode=0, M_TVALID=0, M_TLAST=0, M_BLKEND=0, M_TDATA=0, M_TUSER=0, S_TREADY=0 during reset.
REQ-031 Reset mid-message SHALL discard the partial message; S_TREADY=1 in the first cycle after ARESETn returns to 1.

Verification
REQ-032 Empty msg, mode 0: one word keep 00 TLAST -> 72 words: 0x0006, 70x 0x0000, 0x8000 with M_TLAST=M_BLKEND=1.
REQ-033 "abc", mode 1: 0x6261 (11), 0x0063 (01,TLAST) -> 0x6261, 0x0663, 65x 0x0000, 0x8000 TLAST; 68 words.
REQ-034 Mode 3, 36 full words TLAST on 36th -> word 36 M_BLKEND=1 M_TLAST=0, then 0x0006, 34x 0x0000, 0x8000 TLAST; 72 words total.
REQ-035 Mode 3, 35 full words + 0x0041 keep 01 TLAST -> word 36 = 0x8641, M_TLAST=M_BLKEND=1; return to IDLE.
REQ-036 Mode 2 message with M_TREADY toggling 1,0,1,0 -> no loss/duplication, outputs stable while stalled, 52-word multiple, S_TREADY=0 in PAD.
REQ-037 ARESETn=0 for 1 cycle after 10 accepted words -> M_TVALID=0 next edge; subsequent "abc" mode 1 reproduces REQ-033 exactly.

Source files
------------

// File: rtl/sha3_pad_axis.sv
// SHA-3 multi-rate padder on a 16-bit AXI-Stream: appends the domain byte, zero fill
// and the closing 0x80 so the SHA core always receives whole rate blocks.
module sha3_pad_axis #(
  parameter int          WIDTH    = 16,
  parameter logic [7:0]  PAD_BYTE = 8'h06
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic [WIDTH-1:0] S_TDATA,
  input  logic [1:0]       S_TKEEP,
  input  logic             S_TLAST,
  input  logic [1:0]       S_TUSER,
  input  logic             S_TVALID,
  output logic             S_TREADY,
  output logic [WIDTH-1:0] M_TDATA,
  output logic             M_TVALID,
  input  logic             M_TREADY,
  output logic             M_TLAST,
  output logic [1:0]       M_TUSER,
  output logic             M_BLKEND
);

  // state | meaning
  // IDLE  | between messages, next accepted word latches the hash mode
  // DATA  | passing message words through
  // PAD   | generating pad words until the rate block closes
  typedef enum logic [1:0] {IDLE, DATA, PAD} state_t;

  state_t     st, nxt_st;
  logic [6:0] wc;
  logic [1:0] mode, cur_mode;
  logic       pad_first, nxt_first;
  logic [6:0] rlast;
  logic       at_end, free, acc, ld, ld_last;
  logic [WIDTH-1:0] ld_data;

  function automatic logic [6:0] rate_last(input logic [1:0] m);
    case (m)
      2'd0:    rate_last = 7'd71;
      2'd1:    rate_last = 7'd67;
      2'd2:    rate_last = 7'd51;
      default: rate_last = 7'd35;
    endcase
  endfunction

  always_comb begin
    // the first word of a message is padded against the mode it carries itself
    cur_mode  = (st == IDLE) ? S_TUSER : mode;
    rlast     = rate_last(cur_mode);
    at_end    = (wc == rlast);
    free      = !M_TVALID || M_TREADY;
    S_TREADY  = ARESETn && (st != PAD) && free;
    acc       = S_TVALID && S_TREADY;
    ld        = 1'b0;
    ld_data   = '0;
    ld_last   = 1'b0;
    nxt_st    = st;
    nxt_first = pad_first;
    if (acc) begin
      nxt_st = DATA;
      if (S_TKEEP == 2'b11) begin
        ld      = 1'b1;
        ld_data = S_TDATA;
        if (S_TLAST) begin
          nxt_st    = PAD;
          nxt_first = 1'b1;
        end
      end else if (S_TKEEP == 2'b01) begin
        ld      = 1'b1;
        ld_data = S_TDATA;
        if (S_TLAST) begin
          ld_data   = {PAD_BYTE | (at_end ? 8'h80 : 8'h00), S_TDATA[7:0]};
          ld_last   = at_end;
          nxt_st    = at_end ? IDLE : PAD;
          nxt_first = 1'b0;
        end
      end else if (S_TLAST) begin
        nxt_st    = PAD;
        nxt_first = 1'b1;
      end
    end else if (st == PAD && free) begin
      ld        = 1'b1;
      ld_data   = {(at_end ? 8'h80 : 8'h00), (pad_first ? PAD_BYTE : 8'h00)};
      ld_last   = at_end;
      nxt_first = 1'b0;
      if (at_end) nxt_st = IDLE;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      st        <= IDLE;
      wc        <= '0;
      mode      <= '0;
      pad_first <= 1'b0;
      M_TVALID  <= 1'b0;
      M_TDATA   <= '0;
      M_TLAST   <= 1'b0;
      M_BLKEND  <= 1'b0;
      M_TUSER   <= '0;
    end else begin
      st        <= nxt_st;
      pad_first <= nxt_first;
      if (acc && st == IDLE) mode <= S_TUSER;
      if (ld) begin
        M_TVALID <= 1'b1;
        M_TDATA  <= ld_data;
        M_TLAST  <= ld_last;
        M_BLKEND <= at_end;
        M_TUSER  <= cur_mode;
        wc       <= at_end ? 7'd0 : wc + 7'd1;
      end else if (M_TREADY) begin
        M_TVALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sha3_pad_axis.sv
// Scoreboard bench for sha3_pad_axis: a byte-level SHA-3 padding model fills the
// expected queue, an independent monitor pops and compares every output handshake.
module tb_sha3_pad_axis;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [15:0] S_TDATA = '0;
  logic [1:0]  S_TKEEP = '0;
  logic        S_TLAST = 1'b0;
  logic [1:0]  S_TUSER = '0;
  logic        S_TVALID = 1'b0;
  logic        S_TREADY;
  logic [15:0] M_TDATA;
  logic        M_TVALID;
  logic        M_TREADY = 1'b1;
  logic        M_TLAST;
  logic [1:0]  M_TUSER;
  logic        M_BLKEND;

  sha3_pad_axis #(.WIDTH(16), .PAD_BYTE(8'h06)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_TDATA(S_TDATA), .S_TKEEP(S_TKEEP), .S_TLAST(S_TLAST), .S_TUSER(S_TUSER),
    .S_TVALID(S_TVALID), .S_TREADY(S_TREADY),
    .M_TDATA(M_TDATA), .M_TVALID(M_TVALID), .M_TREADY(M_TREADY),
    .M_TLAST(M_TLAST), .M_TUSER(M_TUSER), .M_BLKEND(M_BLKEND)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        blkend;
    logic [1:0]  user;
  } beat_t;

  beat_t       sb[$];
  logic [15:0] wq_data[$];
  logic [1:0]  wq_keep[$];
  int n_cmp = 0;
  int n_bad = 0;
  int msgs_sent = 0;
  int msgs_done = 0;
  int rdy_mode = 0;
  int out_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: message bytes, then 0x06, zero fill to a rate multiple, 0x80 on the final byte.
  task automatic model(input logic [1:0] mode);
    logic [7:0] bq[$];
    int r;
    int nw;
    beat_t b;
    r = (mode == 2'd0) ? 72 : (mode == 2'd1) ? 68 : (mode == 2'd2) ? 52 : 36;
    foreach (wq_data[i]) begin
      if (wq_keep[i] == 2'b11) begin
        bq.push_back(wq_data[i][7:0]);
        bq.push_back(wq_data[i][15:8]);
      end else if (wq_keep[i] == 2'b01) begin
        bq.push_back(wq_data[i][7:0]);
      end
    end
    bq.push_back(8'h06);
    while (bq.size() % (2 * r) != 0) bq.push_back(8'h00);
    bq[bq.size() - 1] = bq[bq.size() - 1] | 8'h80;
    nw = bq.size() / 2;
    for (int i = 0; i < nw; i++) begin
      b.data   = {bq[2*i+1], bq[2*i]};
      b.last   = (i == nw - 1);
      b.blkend = ((i % r) == r - 1);
      b.user   = mode;
      sb.push_back(b);
    end
  endtask

  // Monitor: compare every handshake and check that stalled outputs hold.
  logic  stalled = 1'b0;
  beat_t held;
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        check("hold", {M_TVALID, M_TDATA, M_TLAST, M_BLKEND, M_TUSER},
              {1'b1, held.data, held.last, held.blkend, held.user});
      if (M_TVALID && M_TREADY) begin
        out_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_word", {M_TDATA, M_TLAST, M_BLKEND, M_TUSER}, 32'hFFFF_FFFF);
        end else begin
          check("out_word", {M_TDATA, M_TLAST, M_BLKEND, M_TUSER}, sb.pop_front());
        end
        if (M_TLAST) msgs_done++;
      end
      stalled = M_TVALID && !M_TREADY;
      held    = '{M_TDATA, M_TLAST, M_BLKEND, M_TUSER};
    end
  end

  initial begin
    forever begin
      @(posedge ACLK);
      #1;
      case (rdy_mode)
        0:       M_TREADY = 1'b1;
        1:       M_TREADY = !M_TREADY;
        default: M_TREADY = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic send_word(input logic [15:0] d, input logic [1:0] k, input logic l,
                           input logic [1:0] u);
    int n;
    n = 0;
    S_TDATA = d; S_TKEEP = k; S_TLAST = l; S_TUSER = u; S_TVALID = 1'b1;
    forever begin
      @(negedge ACLK);
      if (S_TREADY) break;
      n++;
      if (n > 5000) begin
        check("s_tready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge ACLK);
    #1;
    S_TVALID = 1'b0;
  endtask

  // Drive the words in wq_*; only the first word carries the real mode.
  task automatic run_msg(input logic [1:0] mode);
    model(mode);
    foreach (wq_data[i]) begin
      send_word(wq_data[i], wq_keep[i], i == wq_data.size() - 1,
                (i == 0) ? mode : 2'($urandom_range(0, 3)));
      if (i == 0) check("no_accept_before_prev_tlast", msgs_done, msgs_sent);
    end
    msgs_sent++;
    wq_data.delete();
    wq_keep.delete();
  endtask

  task automatic add(input logic [15:0] d, input logic [1:0] k);
    wq_data.push_back(d);
    wq_keep.push_back(k);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(posedge ACLK);
      n++;
    end
    check("drain_left", sb.size(), 0);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_m_tvalid", M_TVALID, 0);
    check("rst_m_tlast", M_TLAST, 0);
    check("rst_m_blkend", M_BLKEND, 0);
    check("rst_m_tdata", M_TDATA, 0);
    check("rst_m_tuser", M_TUSER, 0);
    check("rst_s_tready", S_TREADY, 0);
  endtask

  initial begin
    int len;
    logic [1:0] m;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check_reset_outputs();
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("s_tready_after_rst", S_TREADY, 1);
    @(posedge ACLK);
    #1;

    // empty message, mode 0
    add(16'h1234, 2'b00);
    run_msg(2'd0);
    drain();
    check("empty_msg_words", out_cnt, 72);

    // "abc", mode 1
    out_cnt = 0;
    add(16'h6261, 2'b11);
    add(16'h0063, 2'b01);
    run_msg(2'd1);
    drain();
    check("abc_words", out_cnt, 68);

    // mode 3, exactly one rate block of data
    out_cnt = 0;
    for (int i = 0; i < 36; i++) add(16'($urandom), 2'b11);
    run_msg(2'd3);
    drain();
    check("full_block_words", out_cnt, 72);

    // mode 3, pad byte and 0x80 share the last byte
    out_cnt = 0;
    for (int i = 0; i < 35; i++) add(16'($urandom), 2'b11);
    add(16'h0041, 2'b01);
    run_msg(2'd3);
    drain();
    check("self_complete_words", out_cnt, 36);

    // mode 2 with alternating downstream ready
    rdy_mode = 1;
    out_cnt = 0;
    for (int i = 0; i < 60; i++) add(16'($urandom), 2'b11);
    run_msg(2'd2);
    drain();
    check("toggle_words", out_cnt, 104);
    rdy_mode = 0;

    // reset after 10 accepted words of an unfinished message
    for (int i = 0; i < 10; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      sb.push_back('{d, 1'b0, 1'b0, 2'd1});
      send_word(d, 2'b11, 1'b0, 2'd1);
    end
    ARESETn = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    check("midrst_m_tvalid", M_TVALID, 0);
    check_reset_outputs();
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    sb.delete();
    msgs_done = msgs_sent;
    @(negedge ACLK);
    check("midrst_s_tready", S_TREADY, 1);
    @(posedge ACLK);
    #1;
    out_cnt = 0;
    add(16'h6261, 2'b11);
    add(16'h0063, 2'b01);
    run_msg(2'd1);
    drain();
    check("abc_after_rst_words", out_cnt, 68);

    // randomized messages under random backpressure
    rdy_mode = 2;
    for (int t = 0; t < 20; t++) begin
      len = $urandom_range(0, 80);
      m = 2'($urandom_range(0, 3));
      for (int i = 0; i < len; i++)
        add(16'($urandom), ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1) * 2) : 2'b11);
      case ($urandom_range(0, 3))
        0:       add(16'($urandom), 2'b11);
        1:       add(16'($urandom), 2'b01);
        2:       add(16'($urandom), 2'b00);
        default: add(16'($urandom), 2'b10);
      endcase
      run_msg(m);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
